// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the multi-channel PWM generator.
//   pwm_mode_t     - edge-aligned or centre-aligned counting
//   pwm_dir_t      - counter direction (only meaningful in centre mode)
//   prescale_bits  - width of the prescaler count, never less than 1 bit
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  function automatic int prescale_bits(input int prescale);
    int bits;
    bits = $clog2(prescale + 1);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared PWM timebase.
//   clk, srst  - clock and synchronous active-high reset
//   enable     - 1 runs the prescaler/counter, 0 holds them at zero (dir UP)
//   mode       - active counting mode (edge or centre)
//   restart    - forces the counter back to 0 / UP (used on a mode change)
//   count      - current counter value c
//   boundary   - high on the tick where c steps to 0 (start of a new period)
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  pwm_mode_t        mode,
  input  logic             restart,
  output logic [WIDTH-1:0] count,
  output logic             boundary
);

  localparam int              PW     = prescale_bits(PRESCALE);
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] C_MAX  = '1;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [PW-1:0]    p_reg, p_next;
  logic [WIDTH-1:0] c_reg, c_next;
  pwm_dir_t         dir_reg, dir_next;
  logic             tick;

  always_comb begin
    tick     = enable && (p_reg == P_LAST);
    // Edge mode wraps MAX->0; centre mode reaches 0 on the 1->0 down step.
    boundary = tick && ((mode == PWM_EDGE) ? (c_reg == C_MAX)
                                           : ((dir_reg == DIR_DOWN) && (c_reg == C_ONE)));
    p_next   = p_reg;
    c_next   = c_reg;
    dir_next = dir_reg;
    if (!enable) begin
      p_next   = '0;
      c_next   = '0;
      dir_next = DIR_UP;
    end else begin
      p_next = tick ? '0 : (p_reg + P_ONE);
      if (tick) begin
        if (mode == PWM_EDGE) begin
          c_next   = c_reg + C_ONE;
          dir_next = DIR_UP;
        end else if (dir_reg == DIR_UP) begin
          if (c_reg == C_MAX) begin
            // Turn around at the top: MAX is visited exactly once per period.
            c_next   = C_MAX - C_ONE;
            dir_next = DIR_DOWN;
          end else begin
            c_next = c_reg + C_ONE;
          end
        end else begin
          c_next = c_reg - C_ONE;
          if (c_reg == C_ONE) begin
            dir_next = DIR_UP;
          end
        end
      end
      if (restart) begin
        c_next   = '0;
        dir_next = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      p_reg   <= '0;
      c_reg   <= '0;
      dir_reg <= DIR_UP;
    end else begin
      p_reg   <= p_next;
      c_reg   <= c_next;
      dir_reg <= dir_next;
    end
  end

  assign count = c_reg;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared timebase.
//   clock_in, reset_in  - clock and synchronous active-high reset
//   enable_in           - 1 runs the timebase, 0 idles (outputs low)
//   center_mode_in      - mode captured alongside the duties on accept
//   value_in            - packed duties, channel k at [k*WIDTH +: WIDTH]
//   value_valid_in      - value_in valid
//   value_ready_out     - shadow register free; transfer on valid && ready
//   pwm_out             - registered PWM outputs
//   period_start_out    - one-clock pulse with the first sample of each period
// New duties land in a shadow register and are committed to the active
// registers only at a period boundary (or immediately while idle), so an
// output never sees a partially updated period.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      enable_in,
  input  logic                      center_mode_in,
  input  logic [CHANNELS*WIDTH-1:0] value_in,
  input  logic                      value_valid_in,
  output logic                      value_ready_out,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start_out
);

  logic [CHANNELS*WIDTH-1:0] shadow_duty_reg;
  pwm_mode_t                 shadow_mode_reg;
  logic                      pending_reg;
  logic [CHANNELS*WIDTH-1:0] active_duty_reg;
  pwm_mode_t                 active_mode_reg;
  logic [CHANNELS-1:0]       pwm_reg;
  logic                      boundary_d_reg;
  logic                      period_start_reg;

  logic [WIDTH-1:0]    count;
  logic                boundary;
  logic                accept;
  logic                commit;
  logic                restart;
  logic [CHANNELS-1:0] hit;

  // An accept needs pending low and a commit needs pending high, so a value
  // accepted on a boundary cycle naturally waits for the following boundary.
  assign accept  = value_valid_in && !pending_reg;
  assign commit  = pending_reg && (boundary || !enable_in);
  assign restart = commit && (shadow_mode_reg != active_mode_reg);

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk     (clock_in),
    .srst    (reset_in),
    .enable  (enable_in),
    .mode    (active_mode_reg),
    .restart (restart),
    .count   (count),
    .boundary(boundary)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      assign hit[gi] = count < active_duty_reg[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      shadow_duty_reg  <= '0;
      shadow_mode_reg  <= PWM_EDGE;
      pending_reg      <= 1'b0;
      active_duty_reg  <= '0;
      active_mode_reg  <= PWM_EDGE;
      pwm_reg          <= '0;
      boundary_d_reg   <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      if (accept) begin
        shadow_duty_reg <= value_in;
        shadow_mode_reg <= pwm_mode_t'(center_mode_in);
        pending_reg     <= 1'b1;
      end else if (commit) begin
        pending_reg     <= 1'b0;
      end
      if (commit) begin
        active_duty_reg <= shadow_duty_reg;
        active_mode_reg <= shadow_mode_reg;
      end
      // The counter reads 0 one clock after the boundary tick and the
      // compare is registered, so the strobe is delayed twice to line up
      // with the first output sample of the new period.
      boundary_d_reg   <= enable_in && boundary;
      period_start_reg <= enable_in && boundary_d_reg;
      pwm_reg          <= enable_in ? hit : '0;
    end
  end

  assign value_ready_out  = !pending_reg;
  assign pwm_out          = pwm_reg;
  assign period_start_out = period_start_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed stimulus for pwm_multi with a
// position-in-period reference model feeding a scoreboard queue; a monitor
// compares every output sample on the falling edge.
module tb_pwm_multi;

  localparam int CH   = 3;
  localparam int W    = 4;
  localparam int PS   = 1;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cm;
  logic [CH*W-1:0] value;
  logic          valid;
  logic          ready;
  logic [CH-1:0] pwm;
  logic          ps;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .enable_in       (en),
    .center_mode_in  (cm),
    .value_in        (value),
    .value_valid_in  (valid),
    .value_ready_out (ready),
    .pwm_out         (pwm),
    .period_start_out(ps)
  );

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          ps;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: time inside the period measured in ticks (m_n) plus
  // prescaler phase (m_p); the counter value is derived arithmetically.
  int m_p, m_n, m_bd, m_mode, m_shmode, m_pend;
  int m_act[CH];
  int m_sh[CH];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pos_to_c(input int n, input int mode);
    if (mode == 0) return n;
    return (n <= MAXV) ? n : (2 * MAXV - n);
  endfunction

  function automatic int period_ticks(input int mode);
    return (mode == 0) ? (MAXV + 1) : (2 * MAXV);
  endfunction

  function automatic bit bnd_pred();
    return en && (m_p == PS) && (m_n + 1 == period_ticks(m_mode));
  endfunction

  task automatic model_reset();
    m_p = 0; m_n = 0; m_bd = 0; m_mode = 0; m_shmode = 0; m_pend = 0;
    for (int k = 0; k < CH; k++) begin
      m_act[k] = 0;
      m_sh[k]  = 0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   cur_c;
    bit   tick, bnd, acc, commit;
    e = '0;
    if (rst) begin
      model_reset();
      e.ready = 1'b1;
    end else begin
      cur_c  = pos_to_c(m_n, m_mode);
      tick   = en && (m_p == PS);
      bnd    = tick && (m_n + 1 == period_ticks(m_mode));
      acc    = valid && (m_pend == 0);
      commit = (m_pend != 0) && (bnd || !en);
      for (int k = 0; k < CH; k++) e.pwm[k] = en && (cur_c < m_act[k]);
      e.ps = en && (m_bd != 0);
      m_bd = (en && bnd) ? 1 : 0;
      if (!en) begin
        m_p = 0; m_n = 0;
      end else if (tick) begin
        m_p = 0; m_n = (m_n + 1) % period_ticks(m_mode);
      end else begin
        m_p++;
      end
      if (commit) begin
        if (m_shmode != m_mode) m_n = 0;
        m_mode = m_shmode;
        for (int k = 0; k < CH; k++) m_act[k] = m_sh[k];
        m_pend = 0;
      end
      if (acc) begin
        for (int k = 0; k < CH; k++) m_sh[k] = int'(value[k*W +: W]);
        m_shmode = int'(cm);
        m_pend   = 1;
      end
      e.ready = (m_pend == 0);
    end
    exp_q.push_back(e);
  endtask

  // One clock: record the expectation for the current inputs, then advance.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input bit mode);
    value[0*W +: W] = W'(d0);
    value[1*W +: W] = W'(d1);
    value[2*W +: W] = W'(d2);
    cm = mode;
  endtask

  task automatic wait_free(input int budget);
    int t = 0;
    while (m_pend != 0 && t < budget) begin cyc(); t++; end
    if (m_pend != 0) chk("wait_free_timeout", 1, 0);
  endtask

  task automatic send(input int d0, input int d1, input int d2, input bit mode);
    wait_free(200);
    set_duty(d0, d1, d2, mode);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask

  task automatic wait_ps(input int budget);
    int t = 0;
    while (ps !== 1'b1 && t < budget) begin cyc(); t++; end
    if (ps !== 1'b1) chk("wait_period_start_timeout", 0, 1);
  endtask

  // Count high samples per channel over one period starting at a strobe.
  task automatic measure(input int len, output int h0, output int h1, output int h2,
                         output int extra_ps);
    h0 = 0; h1 = 0; h2 = 0; extra_ps = 0;
    for (int i = 0; i < len; i++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      h2 += int'(pwm[2]);
      if (i > 0) extra_ps += int'(ps);
      cyc();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", int'(pwm), int'(e.pwm));
      chk("period_start_out", int'(ps), int'(e.ps));
      chk("value_ready_out", int'(ready), int'(e.ready));
    end
  end

  initial begin
    int h0, h1, h2, xps, t;
    rst = 1'b1; en = 1'b0; cm = 1'b0; valid = 1'b0; value = '0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(2);

    // Edge mode {0,8,15}: per 32-clock period 0, 16 and 30 high clocks.
    en = 1'b1;
    send(0, 8, 15, 1'b0);
    wait_free(100);
    wait_ps(100);
    measure(32, h0, h1, h2, xps);
    chk("edge_ch0_high", h0, 0);
    chk("edge_ch1_high", h1, 16);
    chk("edge_ch2_high", h2, 30);
    chk("edge_extra_strobe", xps, 0);
    chk("edge_period_32", int'(ps), 1);

    // Mid-period update from 8 to 4.
    send(8, 8, 8, 1'b0);
    idle(20);
    send(4, 4, 4, 1'b0);
    idle(70);

    // Centre mode duty 5: 60-clock period, c<5 on 9 of 30 tick slots.
    send(5, 5, 5, 1'b1);
    wait_free(100);
    wait_ps(100);
    measure(60, h0, h1, h2, xps);
    chk("centre_ch0_high", h0, 18);
    chk("centre_extra_strobe", xps, 0);
    chk("centre_period_60", int'(ps), 1);

    // Valid held for 3 clocks with changing data: only the first is taken.
    wait_free(200);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_duty(3 + i, 7 + i, 11 + i, 1'b1);
      cyc();
    end
    valid = 1'b0;
    wait_free(200);
    idle(5);
    // Valid on the boundary cycle itself.
    t = 0;
    while (!bnd_pred() && t < 200) begin cyc(); t++; end
    set_duty(2, 9, 14, 1'b1);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    idle(130);

    // Reset mid-period with pending data.
    send(1, 1, 1, 1'b0);
    idle(3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle(40);

    // Disable with pending 12, then re-enable.
    send(12, 12, 12, 1'b0);
    en = 1'b0;
    idle(4);
    en = 1'b1;
    idle(70);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 24) != 0);
      valid = ($urandom_range(0, 5) == 0);
      cm    = 1'($urandom_range(0, 1));
      for (int k = 0; k < CH; k++) begin
        case ($urandom_range(0, 3))
          0:       value[k*W +: W] = '0;
          1:       value[k*W +: W] = W'(MAXV);
          default: value[k*W +: W] = W'($urandom_range(0, MAXV));
        endcase
      end
      cyc();
    end
    rst = 1'b0; valid = 1'b0;
    idle(2);

    t = 0;
    while (exp_q.size() > 0 && t < 10) begin #10; t++; end
    if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
